// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time program loader.
//   END_MARKER      - word that terminates the program image
//   state_e         - loader mode (LOAD while receiving the image, RUN after)
//   *_DEF           - default widths for the loader and its input FIFO
package loader_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 14;
    localparam int unsigned FIFO_LOG2_DEF  = 4;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    // True when an assembled word is the end-of-image marker.
    function automatic logic is_marker(input logic [31:0] word);
        return (word == END_MARKER);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO.
//   clk, rst      - clock, asynchronous active-high reset (empties the FIFO)
//   push_i/data_i - write request and byte
//   pop_i         - read request; ignored while empty
//   data_o        - head byte (0 while empty)
//   full_o/empty_o- occupancy flags
//   drop_o        - a push was refused because the FIFO was full and not popped
module byte_fifo #(
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   count_q,  count_d;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Count reaches exactly DEPTH when full, so its MSB alone flags full.
    assign full_o  = count_q[FIFO_LOG2];
    assign empty_o = (count_q == '0);
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // Pop only real data; a push into a full FIFO is accepted when a pop frees a slot.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        drop_o    = push_i && full_o && !do_pop_s;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(FIFO_LOG2-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(FIFO_LOG2-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{FIFO_LOG2{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{FIFO_LOG2{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: assembles UART bytes into big-endian words, writes them to
// instruction memory until END_MARKER, then buffers further bytes for the CPU.
//   rx_data/rx_changed            - byte stream from the UART receiver
//   imem_we/imem_addr/imem_wdata  - one-cycle instruction-memory write
//   load_done                     - image complete (RUN mode)
//   word_count                    - words written, saturating at 2^ADDR_WIDTH
//   in_data/in_valid/in_ready     - FIFO head handshake towards the CPU
//   overflow                      - sticky: a word or byte was dropped
module inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned FIFO_LOG2  = FIFO_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_changed,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [7:0]            in_data,
    output logic                  in_valid,
    input  logic                  in_ready,
    output logic                  overflow
);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           sh_q, sh_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  load_done_q, load_done_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           word_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  drop_s;

    assign word_s = {sh_q, rx_data};
    assign push_s = (state_q == RUN) && rx_changed;
    assign pop_s  = !empty_s && in_ready;

    byte_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (rx_data),
        .pop_i   (pop_s),
        .data_o  (in_data),
        .full_o  (full_s),
        .empty_o (empty_s),
        .drop_o  (drop_s)
    );

    // Word assembly, memory write generation and mode transition.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q || drop_s;
        case (state_q)
            LOAD: begin
                if (rx_changed && (idx_q != 2'd3)) begin
                    sh_d  = {sh_q[15:0], rx_data};
                    idx_d = idx_q + 2'd1;
                end else if (rx_changed) begin
                    idx_d = 2'd0;
                    if (is_marker(word_s)) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end else if (word_count_q[ADDR_WIDTH]) begin
                        // Memory already holds 2^ADDR_WIDTH words: drop, count saturates.
                        overflow_d = 1'b1;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = word_s;
                        word_count_d = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Loader state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            idx_q        <= 2'd0;
            sh_q         <= 24'h000000;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0000_0000;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            word_count_q <= word_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign in_valid   = !empty_s;
    assign overflow   = overflow_q;

endmodule
